// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channels plus the memory load port
// shared between the pipeline front end and the instruction memory.
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic [31:0] rsp_addr;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid,
        output req_addr,
        output flush,
        output rsp_ready,
        output load_en,
        output load_addr,
        output load_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr,
        input  rsp_err,
        input  rsp_addr
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  flush,
        input  rsp_ready,
        input  load_en,
        input  load_addr,
        input  load_data,
        output req_ready,
        output rsp_valid,
        output rsp_instr,
        output rsp_err,
        output rsp_addr
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory answering one outstanding fetch at a time
// after a fixed latency; a load port fills it, flush drops a fetch.
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input logic                    clk,
    input logic                    reset,
    imem_fetch_responder_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rdy_q;
    logic          vld_q;
    logic          err_q;
    logic          rerr_q;
    logic [31:0]   instr_q;
    logic [31:0]   addr_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   req_off;
    logic [31:0]   ld_off;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] ld_idx;
    logic          req_err;
    logic          ld_ok;
    logic          accept;

    // Offsets wrap, so addresses below the base land far out of range.
    assign req_off = bus.req_addr - BASE_ADDR;
    assign ld_off  = bus.load_addr - BASE_ADDR;
    assign req_idx = req_off[AW+1:2];
    assign ld_idx  = ld_off[AW+1:2];

    assign req_err = (bus.req_addr[1:0] != 2'b00) || (req_off >= SPAN);
    assign ld_ok   = bus.load_en
                  && (bus.load_addr[1:0] == 2'b00)
                  && (ld_off < SPAN);

    // rdy_q is only ever set while idle; it stays low through reset.
    assign accept  = (state_q == IDLE) && rdy_q
                  && !bus.flush && bus.req_valid;

    assign bus.req_ready = rdy_q && !bus.flush;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_err   = rerr_q;
    assign bus.rsp_instr = instr_q;
    assign bus.rsp_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_q[ld_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rerr_q  <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        rdy_q   <= 1'b0;
                        addr_q  <= bus.req_addr;
                        err_q   <= req_err;
                        cnt_q   <= CW'(LATENCY - 1);
                        // Nonblocking read sees the word before any same-edge load.
                        instr_q <= req_err ? NOP_INSTR : mem_q[req_idx];
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            vld_q   <= 1'b1;
                            rerr_q  <= req_err;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else if (cnt_q <= CW'(1)) begin
                        state_q <= RESP;
                        vld_q   <= 1'b1;
                        rerr_q  <= err_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // A flush alongside the handshake still discards the response.
                    if (bus.flush || bus.rsp_ready) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                        rerr_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rerr_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
